div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (multiple of 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pause  input  1  pipeline hold; freezes controller state and outputs.
REQ-005 SHALL have port flush  input  1  abandon in-flight operation.
REQ-006 SHALL have port valid_in  input  1  operation request.
REQ-007 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-008 SHALL have port rs1  input  WIDTH  dividend.
REQ-009 SHALL have port rs2  input  WIDTH  divisor.
REQ-010 SHALL have port busy  output  1  high whenever state != IDLE or core draining.
REQ-011 SHALL have port valid_out  output  1  one-cycle result strobe (held while paused).
REQ-012 SHALL have port result  output  WIDTH  quotient or remainder per op.

Function
REQ-013 SHALL accept a request when valid_in=1, state IDLE, pause=0, flush=0, no drain pending; otherwise valid_in is ignored.
REQ-014 SHALL implement states IDLE, RUN, DONE: IDLE->DONE on special case or cache hit; IDLE->RUN otherwise; RUN->DONE after core completion; DONE->IDLE after one unpaused cycle.
REQ-015 SHALL resolve special cases in the accept cycle, valid_out in cycle N+1: divisor 0 -> q=all-ones, r=rs1; signed rs1=0x80..0 with rs2=all-ones -> q=rs1, r=0; rs1=0 -> q=0, r=0.
REQ-016 SHALL, for signed ops, divide |rs1| by |rs2| unsigned, negate q when rs1 and rs2 signs differ, and negate r when rs1 is negative; unsigned ops pass operands unchanged.
REQ-017 SHALL drive the core start in the accept cycle with the absolute operands, only when core ready=1.
REQ-018 SHALL capture core q/r on core vout regardless of pause, and register the sign-corrected result for DONE.
REQ-019 SHALL keep a one-entry cache (rs1, rs2, op[0], q, r, valid) written only on a completed core operation; hit = valid and all three keys equal; a hit returns q or r (per op[1]) with valid_out in N+1.
REQ-020 SHALL hold state, result and valid_out while pause=1; a core completion during pause is latched and consumed when pause drops.
REQ-021 SHALL on flush (priority over pause and valid_in) go to IDLE next cycle, drop valid_out, invalidate the cache, and if the core is running set drain, holding busy=1 until core vout, whose result is discarded.
REQ-022 SHALL compute negation/absolute values modulo 2^WIDTH (abs(0x80..0)=0x80..0).

Reset
REQ-023 SHALL on reset set state IDLE, busy=0, valid_out=0, result=0, drain=0, cache valid=0, and reset the core in the same cycle; reset mid-RUN abandons the operation with no valid_out.

Structure
REQ-024 SHALL take op encodings, state encoding and default WIDTH from shared package div_pkg.
REQ-025 SHALL instantiate exactly one sub-module, the unsigned radix-4 divider core divu_radix4, sharing clk/reset/pause.

Verification
REQ-026 SHALL check DIVU 100/7 -> result 14 after core run; then REMU 100/7 -> 2 with valid_out one cycle after accept (cache hit).
REQ-027 SHALL check DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
REQ-028 SHALL check DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each in N+1 with no core start.
REQ-029 SHALL check flush two cycles into RUN: valid_out never asserts, busy stays 1 until core vout, next DIVU 9/3 -> 3 is not a stale cache hit.
REQ-030 SHALL check pause asserted across core vout for 3 cycles: valid_out rises only after pause drops with correct result; reset mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divide controller: op encodings, FSM states, default width.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } div_state_e;

   function automatic logic is_signed_op(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/divu_radix4.sv
// Unsigned radix-4 iterative divider: two quotient bits per cycle, WIDTH/2 iterations.
module divu_radix4 import div_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pause,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             vout,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam int STEPS = WIDTH / 2;
   localparam int CW    = $clog2(STEPS + 1);

   logic             running;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_p0;
   logic [WIDTH-1:0] rem_p0;
   logic [WIDTH-1:0] dvs_p0;

   logic [WIDTH+1:0] sh, d1, d2, d3, diff;
   logic [1:0]       qd;
   logic [WIDTH-1:0] acc_n, rem_n;

   // Partial remainder is always below the divisor, so the shifted value is below 4*d.
   always_comb begin
      sh = {rem_p0, acc_p0[WIDTH-1 -: 2]};
      d1 = {2'b00, dvs_p0};
      d2 = {1'b0, dvs_p0, 1'b0};
      d3 = d1 + d2;
      qd = 2'd0;
      diff = sh;
      if (sh >= d3) begin
         qd = 2'd3;
         diff = sh - d3;
      end else if (sh >= d2) begin
         qd = 2'd2;
         diff = sh - d2;
      end else if (sh >= d1) begin
         qd = 2'd1;
         diff = sh - d1;
      end
      rem_n = diff[WIDTH-1:0];
      acc_n = {acc_p0[WIDTH-3:0], qd};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         running <= 1'b0;
         vout    <= 1'b0;
         cnt     <= '0;
      end else begin
         vout <= 1'b0;
         if (running) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               running <= 1'b0;
               vout    <= 1'b1;
            end
         end else if (start && !pause) begin
            running <= 1'b1;
            cnt     <= CW'(STEPS);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (running) begin
         acc_p0 <= acc_n;
         rem_p0 <= rem_n;
      end else if (start && !pause) begin
         acc_p0 <= dividend;
         rem_p0 <= '0;
         dvs_p0 <= divisor;
      end
   end

   assign ready = !running;
   assign q     = acc_p0;
   assign r     = rem_p0;

endmodule

// File: rtl/div_ctrl.sv
// Divide/remainder controller: sign handling, special cases, one-entry result cache,
// pause/flush sequencing around the iterative unsigned core.
module div_ctrl import div_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pause,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             busy,
   output logic             valid_out,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   function automatic logic [WIDTH-1:0] neg_mod(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
      return n ? neg_mod(x) : x;
   endfunction

   div_state_e       state;
   logic             drain, pend, cache_vld;
   logic             core_ready, core_vout, core_start;
   logic [WIDTH-1:0] core_q, core_r, qc, rc;
   logic [WIDTH-1:0] k_rs1, k_rs2, c_rs1, c_rs2, c_q, c_r, q_cap, r_cap;
   logic             k_op0, c_op0, neg_q, neg_r, want_rem;
   logic             sgn, s1, s2, accept, special, hit;
   logic [WIDTH-1:0] sp_q, sp_r;

   assign sgn = is_signed_op(op);
   assign s1  = sgn && rs1[WIDTH-1];
   assign s2  = sgn && rs2[WIDTH-1];

   always_comb begin
      special = 1'b0;
      sp_q    = '0;
      sp_r    = '0;
      if (rs2 == '0) begin
         special = 1'b1;
         sp_q    = ONES;
         sp_r    = rs1;
      end else if (sgn && rs1 == MIN && rs2 == ONES) begin
         special = 1'b1;
         sp_q    = rs1;
      end else if (rs1 == '0) begin
         special = 1'b1;
      end
   end

   assign hit        = cache_vld && rs1 == c_rs1 && rs2 == c_rs2 && op[0] == c_op0;
   assign accept     = valid_in && state == ST_IDLE && !pause && !flush && !drain;
   assign core_start = accept && !special && !hit && core_ready;
   assign qc         = cond_neg(core_q, neg_q);
   assign rc         = cond_neg(core_r, neg_r);
   assign busy       = (state != ST_IDLE) || drain;

   divu_radix4 #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .pause    (pause),
      .start    (core_start),
      .dividend (cond_neg(rs1, s1)),
      .divisor  (cond_neg(rs2, s2)),
      .ready    (core_ready),
      .vout     (core_vout),
      .q        (core_q),
      .r        (core_r)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         valid_out <= 1'b0;
         result    <= '0;
         drain     <= 1'b0;
         pend      <= 1'b0;
         cache_vld <= 1'b0;
      end else if (flush) begin
         state     <= ST_IDLE;
         valid_out <= 1'b0;
         pend      <= 1'b0;
         cache_vld <= 1'b0;
         drain     <= (drain && !core_vout) || !core_ready;
      end else begin
         if (drain && core_vout)
            drain <= 1'b0;
         unique case (state)
            ST_IDLE: if (accept) begin
               if (special) begin
                  result    <= op[1] ? sp_r : sp_q;
                  valid_out <= 1'b1;
                  state     <= ST_DONE;
               end else if (hit) begin
                  result    <= op[1] ? c_r : c_q;
                  valid_out <= 1'b1;
                  state     <= ST_DONE;
               end else if (core_ready) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (core_vout)
                  cache_vld <= 1'b1;
               // A completion seen while paused is parked in pend and q_cap/r_cap.
               if (pause) begin
                  if (core_vout)
                     pend <= 1'b1;
               end else if (core_vout || pend) begin
                  result    <= want_rem ? (pend ? r_cap : rc) : (pend ? q_cap : qc);
                  valid_out <= 1'b1;
                  pend      <= 1'b0;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: if (!pause) begin
               state     <= ST_IDLE;
               valid_out <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (core_start) begin
         k_rs1    <= rs1;
         k_rs2    <= rs2;
         k_op0    <= op[0];
         neg_q    <= s1 ^ s2;
         neg_r    <= s1;
         want_rem <= op[1];
      end
      if (core_vout) begin
         q_cap <= qc;
         r_cap <= rc;
      end
      if (state == ST_RUN && core_vout && !flush) begin
         c_rs1 <= k_rs1;
         c_rs2 <= k_rs2;
         c_op0 <= k_op0;
         c_q   <= qc;
         c_r   <= rc;
      end
   end

endmodule
